// File: rtl/tx_serializer.sv
// Serial transmit source for a 1-bit tx data path. It shifts out LSB-first data words,
// or produces a PRBS7 stream, a constant idle level or a 1010 clock pattern.
module tx_serializer #(
  parameter int unsigned WIDTH     = 16,
  parameter logic [6:0]  PRBS_SEED = 7'h7F,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             data_o,
  input  logic             clr_i,
  output logic [7:0]       underflow_o
);

  localparam int unsigned          CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    MODE_DATA   = 2'd0,
    MODE_PRBS   = 2'd1,
    MODE_IDLE   = 2'd2,
    MODE_CLKPAT = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q;
  mode_e            mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sreg_q;
  logic [6:0]       lfsr_q;
  logic             toggle_q;
  logic             data_q;
  logic [7:0]       underflow_q;

  logic             mode_chg_d;
  logic             word_done_d;
  logic             ready_d;
  logic             accept_d;
  logic             underrun_d;
  logic             lfsr_fb_d;

  assign mode_chg_d  = (mode_i != mode_q);
  assign word_done_d = (cnt_q == CNT_FULL);
  assign ready_d     = (mode_i == MODE_DATA) && (mode_q == MODE_DATA) &&
                       ((state_q == ST_IDLE) || word_done_d);
  assign accept_d    = valid_i && ready_d;
  // A finished word with nothing queued behind it is an underrun; a mode change
  // discards the word instead and is never counted.
  assign underrun_d  = !mode_chg_d && (mode_q == MODE_DATA) && (state_q == ST_SHIFT) &&
                       word_done_d && !accept_d;
  assign lfsr_fb_d   = lfsr_q[6] ^ lfsr_q[5];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_DATA;
      cnt_q       <= '0;
      sreg_q      <= '0;
      lfsr_q      <= PRBS_SEED;
      toggle_q    <= 1'b1;
      data_q      <= IDLE_BIT;
      underflow_q <= 8'd0;
    end else begin
      if (clr_i) begin
        underflow_q <= 8'd0;
      end else if (underrun_d && (underflow_q != 8'hFF)) begin
        underflow_q <= underflow_q + 8'd1;
      end

      if (mode_chg_d) begin
        mode_q   <= mode_e'(mode_i);
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        lfsr_q   <= PRBS_SEED;
        toggle_q <= 1'b1;
        data_q   <= IDLE_BIT;
      end else begin
        case (mode_q)
          MODE_DATA: begin
            if (accept_d) begin
              data_q  <= word_i[0];
              sreg_q  <= word_i >> 1;
              cnt_q   <= CNT_ONE;
              state_q <= ST_SHIFT;
            end else if ((state_q == ST_SHIFT) && !word_done_d) begin
              data_q <= sreg_q[0];
              sreg_q <= sreg_q >> 1;
              cnt_q  <= cnt_q + CNT_ONE;
            end else begin
              data_q  <= IDLE_BIT;
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end
          end
          MODE_PRBS: begin
            data_q <= lfsr_fb_d;
            lfsr_q <= {lfsr_q[5:0], lfsr_fb_d};
          end
          MODE_IDLE: begin
            data_q <= IDLE_BIT;
          end
          MODE_CLKPAT: begin
            data_q   <= toggle_q;
            toggle_q <= ~toggle_q;
          end
        endcase
      end
    end
  end

  assign ready_o     = ready_d;
  assign data_o      = data_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: a cycle table for the data path plus
// hand-written sequences for PRBS7, CLKPAT, mode changes, saturation and reset.
module tb_tx_serializer;

  localparam int   WIDTH = 16;
  localparam logic IB    = 1'b0;
  localparam logic [1:0] M_DATA = 2'd0, M_PRBS = 2'd1, M_IDLE = 2'd2, M_CLK = 2'd3;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic [1:0]       mode_i = M_DATA;
  logic [WIDTH-1:0] word_i = '0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic             data_o;
  logic             clr_i = 1'b0;
  logic [7:0]       underflow_o;

  int checks = 0;
  int errors = 0;

  tx_serializer #(.WIDTH(WIDTH), .PRBS_SEED(7'h7F), .IDLE_BIT(IB)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .mode_i(mode_i), .word_i(word_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .clr_i(clr_i),
    .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] word;
    logic        valid;
    logic        clr;
    logic        exp_ready;
    logic        exp_data;
    logic [7:0]  exp_uf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [1:0] m, input logic [15:0] w, input logic v,
                              input logic c, input logic er, input logic ed, input logic [7:0] eu);
    vec_t t;
    t.mode = m; t.word = w; t.valid = v; t.clr = c;
    t.exp_ready = er; t.exp_data = ed; t.exp_uf = eu;
    vecs.push_back(t);
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    @(negedge clk_i);
    mode_i = M_DATA; word_i = w; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  bit a5c3_bits[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
  bit prbs_first[7] = '{0,0,0,0,0,0,1};
  bit prbs_bits[254];

  initial begin
    logic [6:0] m;
    logic       fb;
    int         mism, run, maxrun;
    logic [7:0] uf_before;

    // ---- table: single words, back-to-back words, clear, mode gating ----
    add(M_DATA, 16'hA5C3, 1, 0, 1, a5c3_bits[0], 0);
    for (int k = 1; k < 16; k++) add(M_DATA, 16'h0000, 0, 0, 0, a5c3_bits[k], 0);
    add(M_DATA, 16'h0000, 0, 0, 1, IB, 1);
    add(M_DATA, 16'h0000, 0, 1, 1, IB, 0);
    add(M_DATA, 16'h0001, 1, 0, 1, 1'b1, 0);
    for (int k = 1; k < 16; k++) add(M_DATA, 16'h8000, 1, 0, 0, 1'b0, 0);
    add(M_DATA, 16'h8000, 1, 0, 1, 1'b0, 0);
    for (int k = 1; k < 16; k++) add(M_DATA, 16'h0000, 0, 0, 0, (k == 15), 0);
    add(M_DATA, 16'h0000, 0, 0, 1, IB, 1);
    add(M_IDLE, 16'hFFFF, 1, 0, 0, IB, 1);
    add(M_IDLE, 16'hFFFF, 1, 0, 0, IB, 1);
    add(M_DATA, 16'hFFFF, 1, 0, 0, IB, 1);
    add(M_DATA, 16'hFFFF, 0, 0, 1, IB, 1);
    add(M_DATA, 16'hFFFF, 0, 0, 1, IB, 1);

    // ---- reset state ----
    #12;
    chk("reset_data", data_o, IB);
    chk("reset_uf", underflow_o, 0);
    chk("reset_ready", ready_o, 1);
    @(negedge clk_i); rst_n_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      mode_i = vecs[i].mode; word_i = vecs[i].word;
      valid_i = vecs[i].valid; clr_i = vecs[i].clr;
      #1;
      chk($sformatf("vec%0d_ready", i), ready_o, vecs[i].exp_ready);
      tick();
      chk($sformatf("vec%0d_data", i), data_o, vecs[i].exp_data);
      chk($sformatf("vec%0d_uf", i), underflow_o, vecs[i].exp_uf);
    end
    @(negedge clk_i); valid_i = 1'b0; clr_i = 1'b0;

    // ---- PRBS7 from reset ----
    rst_n_i = 1'b0; mode_i = M_PRBS;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
    chk("prbs_entry", data_o, IB);
    for (int i = 0; i < 254; i++) begin
      tick();
      prbs_bits[i] = data_o;
    end
    for (int i = 0; i < 7; i++) chk($sformatf("prbs_bit%0d", i), prbs_bits[i], prbs_first[i]);
    m = 7'h7F; mism = 0;
    for (int i = 0; i < 254; i++) begin
      fb = m[6] ^ m[5];
      m = {m[5:0], fb};
      if (prbs_bits[i] != fb) mism++;
    end
    chk("prbs_model", mism, 0);
    mism = 0;
    for (int i = 0; i < 127; i++) if (prbs_bits[i] != prbs_bits[i+127]) mism++;
    chk("prbs_period", mism, 0);
    run = 0; maxrun = 0;
    for (int i = 0; i < 254; i++) begin
      run = prbs_bits[i] ? 0 : run + 1;
      if (run > maxrun) maxrun = run;
    end
    chk("prbs_zero_run", maxrun, 6);

    // ---- CLKPAT, then back to DATA ----
    @(negedge clk_i); mode_i = M_CLK;
    tick();
    chk("clk_entry", data_o, IB);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("clk_bit%0d", i), data_o, (i % 2 == 0));
    end
    @(negedge clk_i); mode_i = M_DATA; #1;
    chk("clk2data_ready_before", ready_o, 0);
    tick();
    chk("clk2data_data", data_o, IB);
    chk("clk2data_ready_after", ready_o, 1);
    chk("clk2data_uf", underflow_o, 0);

    // ---- DATA mid-word switched to CLKPAT: word discarded, no underrun ----
    send_word(16'hFFFF);
    repeat (4) tick();
    chk("mid_word_bit", data_o, 1);
    @(negedge clk_i); mode_i = M_CLK;
    tick();
    chk("mid_switch_data", data_o, IB);
    tick();
    chk("mid_switch_clk_first", data_o, 1);
    @(negedge clk_i); mode_i = M_DATA;
    repeat (20) tick();
    chk("mid_switch_data_idle", data_o, IB);
    chk("mid_switch_uf", underflow_o, 0);

    // ---- saturation after 300 underruns ----
    for (int n = 1; n <= 300; n++) begin
      send_word(16'h00FF);
      repeat (16) tick();
      if (n == 200) chk("uf_200", underflow_o, 200);
      if (n == 255) chk("uf_255", underflow_o, 255);
    end
    chk("uf_saturated", underflow_o, 255);

    // ---- clear on the same edge as an underrun ----
    send_word(16'h00FF);
    repeat (15) tick();
    uf_before = underflow_o;
    @(negedge clk_i); clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("clr_vs_underrun_before", uf_before, 255);
    chk("clr_vs_underrun", underflow_o, 0);
    send_word(16'h00FF);
    repeat (16) tick();
    chk("uf_after_clr", underflow_o, 1);

    // ---- asynchronous reset mid-word ----
    send_word(16'hFFFF);
    repeat (7) tick();
    chk("pre_reset_bit", data_o, 1);
    #3; rst_n_i = 1'b0; #1;
    chk("async_reset_data", data_o, IB);
    chk("async_reset_uf", underflow_o, 0);
    chk("reset_ready_data", ready_o, 1);
    mode_i = M_IDLE; #1;
    chk("reset_ready_idle", ready_o, 0);
    mode_i = M_DATA; valid_i = 1'b1; word_i = 16'hFFFF;
    repeat (2) tick();
    chk("reset_no_accept", data_o, IB);
    @(negedge clk_i); rst_n_i = 1'b1; valid_i = 1'b0;
    tick();
    chk("release_data", data_o, IB);
    tick();
    chk("release_idle", data_o, IB);
    chk("release_uf", underflow_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
